// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock, LSB first. The sum is shifted into result from the MSB
// end. A one-cycle done pulse flags result, cout and overflow as valid.
module serial_add_unit #(
  parameter int unsigned WIDTH = 8  // must be >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_a, fa_b, fa_r, fa_co;
  logic last_bit;

  // Single full-adder cell fed from the operand LSBs and the carry flop
  always_comb begin
    fa_a  = a_q[0];
    fa_b  = b_q[0];
    fa_r  = fa_a ^ fa_b ^ carry_q;
    fa_co = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  end

  assign last_bit = (count_q == LastBit);

  // Next-state logic: operand load on accepted start, shift/accumulate in RUN
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    count_d  = count_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          count_d = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        // start is deliberately not looked at here; requests during RUN are dropped
        result_d = {fa_r, result_q[WIDTH-1:1]};
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        carry_d  = fa_co;
        if (last_bit) begin
          // Carry into the MSB is carry_q, carry out of it is fa_co
          ovf_d   = carry_q ^ fa_co;
          cout_d  = fa_co;
          state_d = StDone;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status outputs decode directly from the registered state
  always_comb begin
    busy     = (state_q == StRun);
    done     = (state_q == StDone);
    result   = result_q;
    cout     = cout_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit: the driver pushes arithmetic-model
// expectations, and a monitor pops and compares them on every done pulse.
module tb_serial_add_unit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy, done, cout, overflow;
  logic [WIDTH-1:0] result;

  serial_add_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Plain integer arithmetic: wrap modulo 2^WIDTH, carry = unsigned out-of-range
  // (or no-borrow for subtraction), overflow = signed result out of range.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input int accept_cyc);
    exp_t e;
    int ua, ub, sa, sb_i, full, sres;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    full = s ? (ua - ub) : (ua + ub);
    sres = s ? (sa - sb_i) : (sa + sb_i);
    e.res = full[WIDTH-1:0];
    e.co  = s ? (ua >= ub) : (full >= (1 << WIDTH));
    e.ov  = (sres > (1 << (WIDTH - 1)) - 1) || (sres < -(1 << (WIDTH - 1)));
    // The accepting edge plus WIDTH bit edges; done is visible after the last one
    e.due = accept_cyc + WIDTH;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("cout", 32'(cout), 32'(e.co));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("done_latency", 32'(cyc), 32'(e.due));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, s, cyc));
    vectors++;
    start = 1'b0;
    op_a  = WIDTH'($urandom);
    op_b  = WIDTH'($urandom);
    sub   = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    checks++;
    miscompares++;
    $display("FAIL done_timeout: got %0d pending ops expected 0", sb.size());
    sb.delete();
  endtask

  initial begin
    // Reset state
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including the carry, overflow and borrow boundaries
    issue(8'h01, 8'h01, 1'b0); wait_idle();
    issue(8'hFF, 8'h01, 1'b0); wait_idle();
    issue(8'h7F, 8'h01, 1'b0); wait_idle();
    issue(8'h80, 8'h80, 1'b0); wait_idle();
    issue(8'h05, 8'h07, 1'b1); wait_idle();
    issue(8'h07, 8'h05, 1'b1); wait_idle();
    issue(8'h80, 8'h01, 1'b1); wait_idle();
    issue(8'h00, 8'h00, 1'b1); wait_idle();

    // start during RUN (sampled at E3) must be ignored
    issue(8'h01, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    op_a  = 8'hAA;
    op_b  = 8'h55;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_ignored_start", 32'(busy), 32'd1);
    wait_idle();
    @(negedge clk);
    check("result_hold", 32'(result), 32'h02);
    check("done_single_pulse", 32'(done), 32'd0);

    // Reset asserted at E4 of a run: outputs clear at once, no done pulse
    issue(8'h12, 8'h34, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_result", 32'(result), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 2) @(negedge clk);  // a stray done here is flagged by the monitor
    issue(8'h3C, 8'h0F, 1'b1); wait_idle();

    // Back-to-back: start held high through DONE with new operands
    begin
      @(negedge clk);
      op_a  = 8'h10;
      op_b  = 8'h20;
      sub   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model(8'h10, 8'h20, 1'b0, cyc));
      vectors++;
      repeat (WIDTH) @(posedge clk);
      #1;
      check("b2b_first_done", 32'(done), 32'd1);
      @(negedge clk);
      op_a = 8'h90;
      op_b = 8'hA0;
      sub  = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model(8'h90, 8'hA0, 1'b1, cyc));
      vectors++;
      start = 1'b0;
      check("b2b_second_busy", 32'(busy), 32'd1);
      check("b2b_done_dropped", 32'(done), 32'd0);
      wait_idle();
    end

    // Randomised operations, sometimes with a stray start mid-run
    for (int n = 0; n < 40; n++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, WIDTH - 3)) @(negedge clk);
        @(negedge clk);
        op_a  = WIDTH'($urandom);
        op_b  = WIDTH'($urandom);
        sub   = 1'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_ops: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
